// File: rtl/alu_mdu_seq_if.sv
// Request/response handshake between the execute stage and the M-extension sequencer.
interface alu_mdu_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_res;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res
    );
endinterface

// File: rtl/alu_mdu_seq.sv
// Iterative RV32M multiply/divide sequencer; all arithmetic goes through the shared
// external ALU, so this block only steers operands and shifts registers.
module alu_mdu_seq #(
    parameter int                    XLEN       = 32,
    parameter int                    ALU_OP_W   = 4,
    parameter logic [ALU_OP_W-1:0]   ALU_OP_ADD  = 4'd0,
    parameter logic [ALU_OP_W-1:0]   ALU_OP_SUB  = 4'd1,
    parameter logic [ALU_OP_W-1:0]   ALU_OP_SLTU = 4'd3,
    parameter logic [ALU_OP_W-1:0]   ALU_OP_XOR  = 4'd4,
    parameter logic [ALU_OP_W-1:0]   ALU_OP_LHS  = 4'd10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    alu_mdu_seq_if.slave        bus,
    output logic                busy,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [XLEN-1:0]     alu_lhs,
    output logic [XLEN-1:0]     alu_rhs,
    input  logic [XLEN-1:0]     alu_res
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_NEG_A = 3'd1;
    localparam logic [2:0] S_NEG_B = 3'd2;
    localparam logic [2:0] S_ITER  = 3'd3;
    localparam logic [2:0] S_FIX1  = 3'd4;
    localparam logic [2:0] S_FIX2  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]      state;
    logic [2:0]      op;
    logic            sa, sb, neg;
    logic [XLEN-1:0] acc;    // hi (multiply) / partial remainder (divide)
    logic [XLEN-1:0] lo;     // lo (multiply) / dividend shifting into quotient
    logic [XLEN-1:0] opnd;   // multiplicand / divisor
    logic [XLEN-1:0] tmp;
    logic            flag, ovf;
    logic [5:0]      cnt;
    logic [XLEN-1:0] res;

    logic            is_div, is_rem, is_mulh;
    logic            in_sa, in_sb, in_div0;
    logic [XLEN-1:0] r_shift, fix_src;

    assign is_div  = op[2];
    assign is_rem  = op[2] & op[1];
    assign is_mulh = ~op[2] & (op[1:0] != 2'b00);

    assign in_sa   = (bus.in_op == 3'd1) | (bus.in_op == 3'd2) |
                     (bus.in_op == 3'd4) | (bus.in_op == 3'd6);
    assign in_sb   = (bus.in_op == 3'd1) | (bus.in_op == 3'd4) | (bus.in_op == 3'd6);
    assign in_div0 = bus.in_op[2] & (bus.in_b == '0);

    assign r_shift = {acc[XLEN-2:0], lo[XLEN-1]};
    assign fix_src = (is_rem | is_mulh) ? acc : lo;

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.out_res   = res;
    assign busy          = (state != S_IDLE);

    // NOTE: every output gets its idle value first, so no path through the case leaves one unassigned (no latch).
    always_comb begin
        alu_op  = ALU_OP_LHS;
        alu_lhs = '0;
        alu_rhs = '0;
        case (state)
            S_NEG_A: begin
                alu_op  = sa ? ALU_OP_SUB : ALU_OP_LHS;
                alu_lhs = sa ? '0 : lo;
                alu_rhs = sa ? lo : '0;
            end
            S_NEG_B: begin
                alu_op  = sb ? ALU_OP_SUB : ALU_OP_LHS;
                alu_lhs = sb ? '0 : opnd;
                alu_rhs = sb ? opnd : '0;
            end
            S_ITER: begin
                if (!is_div) begin
                    if (!cnt[0]) begin
                        alu_op  = ALU_OP_ADD;
                        alu_lhs = acc;
                        alu_rhs = lo[0] ? opnd : '0;
                    end else begin
                        alu_op  = ALU_OP_SLTU;   // carry out of the add above
                        alu_lhs = tmp;
                        alu_rhs = acc;
                    end
                end else begin
                    if (!cnt[0]) begin
                        alu_op  = ALU_OP_SLTU;
                        alu_lhs = r_shift;
                        alu_rhs = opnd;
                    end else begin
                        alu_op  = ALU_OP_SUB;
                        alu_lhs = acc;
                        alu_rhs = opnd;
                    end
                end
            end
            S_FIX1: begin
                if (is_mulh) begin
                    alu_op  = neg ? ALU_OP_XOR : ALU_OP_LHS;
                    alu_lhs = acc;
                    alu_rhs = neg ? '1 : '0;
                end else begin
                    alu_op  = neg ? ALU_OP_SUB : ALU_OP_LHS;
                    alu_lhs = neg ? '0 : fix_src;
                    alu_rhs = neg ? fix_src : '0;
                end
            end
            S_FIX2: begin
                // Two's-complement of {hi,lo}: ~hi plus the carry out of ~lo+1.
                if (is_mulh && neg) begin
                    alu_op  = ALU_OP_ADD;
                    alu_rhs = {{(XLEN-1){1'b0}}, (lo == '0)};
                end
                alu_lhs = tmp;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op    <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            neg   <= 1'b0;
            acc   <= '0;
            lo    <= '0;
            opnd  <= '0;
            tmp   <= '0;
            flag  <= 1'b0;
            ovf   <= 1'b0;
            cnt   <= '0;
            res   <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op    <= bus.in_op;
                        sa    <= in_sa & bus.in_a[XLEN-1];
                        sb    <= in_sb & bus.in_b[XLEN-1];
                        neg   <= in_div0 ? 1'b0 :
                                 (bus.in_op == 3'd6) ? (in_sa & bus.in_a[XLEN-1]) :
                                 ((in_sa & bus.in_a[XLEN-1]) ^ (in_sb & bus.in_b[XLEN-1]));
                        lo    <= bus.in_a;
                        opnd  <= bus.in_b;
                        acc   <= '0;
                        cnt   <= '0;
                        if (in_div0) begin
                            res   <= bus.in_op[1] ? bus.in_a : '1;
                            state <= S_DONE;
                        end else begin
                            state <= S_NEG_A;
                        end
                    end
                end
                S_NEG_A: begin
                    lo    <= alu_res;
                    state <= S_NEG_B;
                end
                S_NEG_B: begin
                    acc <= '0;
                    if (!is_div) begin
                        lo   <= alu_res;   // multiplier |b| shifts out of lo
                        opnd <= lo;        // multiplicand |a|
                    end else begin
                        opnd <= alu_res;
                    end
                    state <= S_ITER;
                end
                S_ITER: begin
                    cnt <= cnt + 6'd1;
                    if (&cnt) state <= S_FIX1;
                    if (!is_div) begin
                        if (!cnt[0]) begin
                            tmp <= alu_res;
                        end else begin
                            acc <= {alu_res[0], tmp[XLEN-1:1]};
                            lo  <= {tmp[0], lo[XLEN-1:1]};
                        end
                    end else begin
                        if (!cnt[0]) begin
                            flag <= alu_res[0];
                            ovf  <= acc[XLEN-1];
                            acc  <= r_shift;
                            lo   <= {lo[XLEN-2:0], 1'b0};
                        end else if (ovf || !flag) begin
                            acc   <= alu_res;
                            lo[0] <= 1'b1;
                        end
                    end
                end
                S_FIX1: begin
                    tmp   <= alu_res;
                    state <= S_FIX2;
                end
                S_FIX2: begin
                    res   <= alu_res;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Self-checking bench: external ALU model, reference model from RV32M arithmetic, scoreboard monitor.
module tb_alu_mdu_seq;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_LHS  = 4'd10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic [3:0]  alu_op;
    logic [31:0] alu_lhs, alu_rhs, alu_res;

    alu_mdu_seq_if #(.XLEN(32)) bus ();

    alu_mdu_seq #(
        .XLEN(32), .ALU_OP_W(4),
        .ALU_OP_ADD(OP_ADD), .ALU_OP_SUB(OP_SUB), .ALU_OP_SLTU(OP_SLTU),
        .ALU_OP_XOR(OP_XOR), .ALU_OP_LHS(OP_LHS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .busy(busy),
        .alu_op(alu_op), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_res(alu_res)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_res = 32'h0;
        case (alu_op)
            OP_ADD:  alu_res = alu_lhs + alu_rhs;
            OP_SUB:  alu_res = alu_lhs - alu_rhs;
            OP_SLTU: alu_res = {31'b0, (alu_lhs < alu_rhs)};
            OP_XOR:  alu_res = alu_lhs ^ alu_rhs;
            OP_LHS:  alu_res = alu_lhs;
            default: alu_res = 32'hDEAD_BEEF;
        endcase
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit rand_ready = 1'b0;
    bit ready_hold = 1'b1;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          start;
        logic [2:0]  op;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;
    vec_t dir_v[12];

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_hold;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait expired at cycle %0d", name, cyc);
    endtask

    // RV32M semantics from 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa_v = longint'($signed(a));
        longint      sb_v = longint'($signed(b));
        longint      ua   = longint'({32'b0, a});
        longint      ub   = longint'({32'b0, b});
        logic [63:0] p;
        logic [31:0] r;
        p = 64'h0;
        r = 32'h0;
        case (op)
            3'd0: begin p = 64'(ua * ub);   r = p[31:0];  end
            3'd1: begin p = 64'(sa_v * sb_v); r = p[63:32]; end
            3'd2: begin p = 64'(sa_v * ub); r = p[63:32]; end
            3'd3: begin p = 64'(ua * ub);   r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa_v / sb_v);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : 32'(sa_v % sb_v);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input bit expect_it);
        int n = 0;
        while (!bus.in_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) timeout_fail("in_ready_wait");
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (expect_it)
            sb_q.push_back('{exp_res, (op[2] && b == 32'h0) ? 0 : 68, cyc, op});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) timeout_fail("scoreboard_drain");
        @(posedge clk);
        #1;
    endtask

    // Monitor: latency on out_valid rise, result on handshake, one-cycle pulse after handshake.
    bit prev_valid = 1'b0;
    bit prev_hs = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_hs) check("valid_drops_after_hs", {31'b0, bus.out_valid}, 32'd0);
            if (bus.out_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out_valid: res 0x%08h with no pending op at cycle %0d",
                             bus.out_res, cyc);
                end else begin
                    check($sformatf("latency_op%0d", sb_q[0].op), 32'(cyc - sb_q[0].start),
                          32'(sb_q[0].lat));
                end
            end
            if (bus.out_valid && bus.out_ready && sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check($sformatf("result_op%0d", e.op), bus.out_res, e.res);
            end
            prev_hs    = bus.out_valid && bus.out_ready;
            prev_valid = bus.out_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        bus.in_valid = 1'b0;
        bus.in_op    = 3'd0;
        bus.in_a     = 32'h0;
        bus.in_b     = 32'h0;

        dir_v[0]  = '{3'd0, 32'd7,          32'd6,          32'h0000_002A};
        dir_v[1]  = '{3'd1, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF};
        dir_v[2]  = '{3'd3, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001};
        dir_v[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF};
        dir_v[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        dir_v[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        dir_v[6]  = '{3'd5, 32'd100,        32'd7,          32'd14};
        dir_v[7]  = '{3'd7, 32'd100,        32'd7,          32'd2};
        dir_v[8]  = '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF};
        dir_v[9]  = '{3'd6, 32'd5,          32'd0,          32'd5};
        dir_v[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        dir_v[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000};

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_busy",      {31'b0, busy},          32'd0);
        check("rst_out_res",   bus.out_res,            32'h0);
        check("rst_alu_op",    {28'b0, alu_op},        {28'b0, OP_LHS});
        check("rst_alu_lhs",   alu_lhs,                32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with fixed expected values
        for (int i = 0; i < 12; i++)
            issue(dir_v[i].op, dir_v[i].a, dir_v[i].b, dir_v[i].res, 1'b1);
        drain(400);

        // Consumer stall: result held for 10 cycles in DONE
        ready_hold = 1'b0;
        @(posedge clk);
        #1;
        issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b1);
        begin
            int n = 0;
            while (!bus.out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!bus.out_valid) timeout_fail("stall_valid_wait");
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_out_res",   bus.out_res,            32'd14);
            check("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
            check("stall_in_ready",  {31'b0, bus.in_ready},  32'd0);
        end
        ready_hold = 1'b1;
        drain(20);

        // Flush at E0+30 drops the operation
        issue(3'd0, 32'd11, 32'd13, 32'd143, 1'b0);
        repeat (29) @(posedge clk);
        #1;
        check("pre_flush_busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy",      {31'b0, busy},          32'd0);
        check("flush_in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
        repeat (80) @(posedge clk);
        #1;

        // Asynchronous reset at E0+40
        issue(3'd4, 32'd1000, 32'd3, 32'd333, 1'b0);
        repeat (40) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("arst_busy",      {31'b0, busy},          32'd0);
        check("arst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("arst_alu_op",    {28'b0, alu_op},        {28'b0, OP_LHS});
        check("arst_alu_rhs",   alu_rhs,                32'h0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(3'd0, 32'd3, 32'd3, 32'd9, 1'b1);
        drain(200);

        // Randomised operations against the reference model, random consumer back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = rand_operand();
            rb  = rand_operand();
            issue(rop, ra, rb, ref_model(rop, ra, rb), 1'b1);
        end
        drain(2000);
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
